// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - two-flop synchroniser and per-bit bounce filter for the switch bank
// Reports each accepted flip as a one-hot lowest-index strobe when armed.
module switch_debouncer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] switch_raw,
    input  logic             arm,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] changed_bit,
    output logic             change_valid,
    output logic             multi_change
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] differ;
    logic [WIDTH-1:0] accepted;
    logic [WIDTH-1:0] lowest;
    logic             several;
    logic [CNT_W-1:0] cnt [WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= switch_raw;
            s2 <= s1;
        end
    end

    always_comb begin
        differ   = s2 ^ sw_clean;
        accepted = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accepted[i] = differ[i] && (cnt[i] == CNT_LAST);
        end
        // x & -x isolates the lowest set bit; x & (x-1) is nonzero iff more than one bit is set
        lowest  = accepted & (~accepted + WIDTH'(1));
        several = |(accepted & (accepted - WIDTH'(1)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            sw_clean <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!differ[i] || accepted[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
            sw_clean <= sw_clean ^ accepted;
        end
    end

    // arm is sampled in the accept cycle, so disarmed flips are never reported later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            changed_bit  <= '0;
            change_valid <= 1'b0;
            multi_change <= 1'b0;
        end else begin
            changed_bit  <= arm ? lowest : '0;
            change_valid <= arm & (|accepted);
            multi_change <= arm & several;
        end
    end

endmodule
